// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// pll_reset_sequencer -- debounces the PLL lock flag and releases memory, co-processor and CPU resets in order.
// Rev 1.0
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 1024,
  parameter int STAGE_GAP     = 16,
  parameter int LOSS_FILTER   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       sw_reset_req,
  output logic       rst_memory,
  output logic       rst_copro,
  output logic       rst_cpu,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_CNT = (SETTLE_CYCLES > STAGE_GAP) ? SETTLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST   = LOSS_W'(LOSS_FILTER - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    REL_MEM   = 3'd2,
    REL_COPRO = 3'd3,
    REL_CPU   = 3'd4,
    RUN       = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_sync;
  state_t                 cur_state;
  state_t                 next_state;
  logic [CNT_W-1:0]       cnt;
  logic [LOSS_W-1:0]      loss_cnt;
  logic                   in_release;
  logic                   loss_event;

  assign locked_sync = sync[SYNC_STAGES-1];
  assign state       = cur_state;
  assign in_release  = cur_state inside {REL_MEM, REL_COPRO, REL_CPU, RUN};
  // The current low sample is the LOSS_FILTER-th in a row, so the drop happens on this edge.
  assign loss_event  = in_release && !locked_sync && (loss_cnt == LOSS_LAST);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], locked};
    end
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      WAIT_LOCK: if (locked_sync) next_state = SETTLE;
      SETTLE: begin
        if (!locked_sync)              next_state = WAIT_LOCK;
        else if (cnt == SETTLE_LAST)   next_state = REL_MEM;
      end
      REL_MEM:   if (cnt == GAP_LAST) next_state = REL_COPRO;
      REL_COPRO: if (cnt == GAP_LAST) next_state = REL_CPU;
      REL_CPU:   if (cnt == GAP_LAST) next_state = RUN;
      RUN:       if (sw_reset_req)    next_state = SETTLE;
      default:                        next_state = WAIT_LOCK;
    endcase
    // Lock loss overrides any other transition, including a software restart.
    if (loss_event) next_state = WAIT_LOCK;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur_state       <= WAIT_LOCK;
      cnt             <= '0;
      loss_cnt        <= '0;
      lock_loss_count <= 8'd0;
      rst_memory      <= 1'b1;
      rst_copro       <= 1'b1;
      rst_cpu         <= 1'b1;
      ready           <= 1'b0;
    end else begin
      cur_state <= next_state;

      if ((next_state != cur_state) ||
          !(next_state inside {SETTLE, REL_MEM, REL_COPRO, REL_CPU})) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (!in_release || loss_event || locked_sync) begin
        loss_cnt <= '0;
      end else begin
        loss_cnt <= loss_cnt + LOSS_W'(1);
      end

      if (loss_event && (lock_loss_count != 8'hFF)) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end

      // Decoded from the next state so outputs change on the same edge as the state.
      rst_memory <= !(next_state inside {REL_MEM, REL_COPRO, REL_CPU, RUN});
      rst_copro  <= !(next_state inside {REL_COPRO, REL_CPU, RUN});
      rst_cpu    <= !(next_state inside {REL_CPU, RUN});
      ready      <= (next_state == RUN);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// tb_pll_reset_sequencer -- bench for pll_reset_sequencer with SETTLE_CYCLES=8, STAGE_GAP=4, LOSS_FILTER=3.
module tb_pll_reset_sequencer;

  localparam int SETTLE = 8;
  localparam int GAP    = 4;

  logic       clock        = 1'b0;
  logic       reset_n      = 1'b0;
  logic       locked       = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic       rst_memory;
  logic       rst_copro;
  logic       rst_cpu;
  logic       ready;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  pll_reset_sequencer #(
    .SYNC_STAGES  (2),
    .SETTLE_CYCLES(SETTLE),
    .STAGE_GAP    (GAP),
    .LOSS_FILTER  (3)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .locked         (locked),
    .sw_reset_req   (sw_reset_req),
    .rst_memory     (rst_memory),
    .rst_copro      (rst_copro),
    .rst_cpu        (rst_cpu),
    .ready          (ready),
    .state          (state),
    .lock_loss_count(lock_loss_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       mem;
    logic       copro;
    logic       cpu;
    logic       rdy;
    logic [2:0] st;
    logic [7:0] llc;
  } exp_t;

  typedef struct {
    logic rn;
    logic lk;
    logic sw;
    exp_t e;
  } vec_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Expected outputs n edges after the edge where the synchronised lock (or restart) becomes visible.
  function automatic exp_t sched(input int n, input logic [7:0] llc);
    exp_t e;
    e.mem   = (n < 1 + SETTLE);
    e.copro = (n < 1 + SETTLE + GAP);
    e.cpu   = (n < 1 + SETTLE + 2 * GAP);
    e.rdy   = (n >= 1 + SETTLE + 3 * GAP);
    if (n < 1)                         e.st = 3'd0;
    else if (n < 1 + SETTLE)           e.st = 3'd1;
    else if (n < 1 + SETTLE + GAP)     e.st = 3'd2;
    else if (n < 1 + SETTLE + 2 * GAP) e.st = 3'd3;
    else if (n < 1 + SETTLE + 3 * GAP) e.st = 3'd4;
    else                               e.st = 3'd5;
    e.llc = llc;
    return e;
  endfunction

  task automatic check_out(input string tag, input int k);
    exp_t e;
    exp_t got;
    e   = sbq.pop_front();
    got = {rst_memory, rst_copro, rst_cpu, ready, state, lock_loss_count};
    n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s[%0d]: got mem=%b copro=%b cpu=%b ready=%b state=%0d llc=%0d, expected mem=%b copro=%b cpu=%b ready=%b state=%0d llc=%0d",
               tag, k, got.mem, got.copro, got.cpu, got.rdy, got.st, got.llc,
               e.mem, e.copro, e.cpu, e.rdy, e.st, e.llc);
    end
    n_checks++;
    if ((!rst_cpu && rst_copro) || (!rst_copro && rst_memory)) begin
      n_fail++;
      $display("FAIL order %s[%0d]: got mem=%b copro=%b cpu=%b, expected release order kept",
               tag, k, rst_memory, rst_copro, rst_cpu);
    end
  endtask

  task automatic tick(input logic rn, input logic lk, input logic sw);
    reset_n      = rn;
    locked       = lk;
    sw_reset_req = sw;
    @(posedge clock);
    #1;
  endtask

  task automatic cyc(input logic rn, input logic lk, input logic sw,
                     input exp_t e, input string tag, input int k);
    sbq.push_back(e);
    tick(rn, lk, sw);
    check_out(tag, k);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    exp_t idle;
    int   n;
    logic lk;

    idle   = sched(0, 8'd0);
    tbl[0] = '{1'b0, 1'b0, 1'b0, idle};
    tbl[1] = '{1'b0, 1'b1, 1'b0, idle};
    tbl[2] = '{1'b0, 1'b1, 1'b1, idle};
    tbl[3] = '{1'b1, 1'b0, 1'b0, idle};
    tbl[4] = '{1'b1, 1'b0, 1'b1, idle};
    tbl[5] = '{1'b1, 1'b0, 1'b0, idle};
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].rn, tbl[i].lk, tbl[i].sw, tbl[i].e, "reset_tbl", i);
    end

    // Clean power-up: locked_sync goes high on the second edge after locked rises.
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b1, 1'b1, 1'b0, sched(k - 2, 8'd0), "powerup", k);
    end

    // Two low samples in RUN are filtered out.
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, (j > 2), 1'b0, sched(30, 8'd0), "filter2", j);
    end

    // Three low samples: loss lands on the same edge as a software request and must win.
    for (int j = 1; j <= 26; j++) begin
      cyc(1'b1, (j > 3), (j == 5), (j <= 4) ? sched(30, 8'd0) : sched(j - 5, 8'd1), "loss3", j);
    end

    // Repeated lock losses in REL_MEM drive the counter into saturation.
    for (int i = 0; i < 260; i++) begin
      for (int t = 1; t <= 17; t++) begin
        if (t == 14) begin
          cyc(1'b1, 1'b1, 1'b0,
              (i == 0) ? sched(30, 8'd1) : sched(10, (1 + i > 255) ? 8'd255 : 8'(1 + i)),
              "sat", i);
        end else begin
          tick(1'b1, (t <= 14), 1'b0);
        end
      end
    end
    tick(1'b1, 1'b1, 1'b0);
    for (int k = 2; k <= 24; k++) begin
      cyc(1'b1, 1'b1, 1'b0, sched(k - 2, 8'd255), "satrec", k);
    end

    // Software restart from RUN; the second pulse lands in REL_COPRO and is ignored.
    for (int k = 1; k <= 22; k++) begin
      cyc(1'b1, 1'b1, (k == 1 || k == 14), sched(k, 8'd255), "swreq", k);
    end

    // Synchronous reset during REL_CPU, then a re-lock with a settle glitch at count 5.
    for (int k = 1; k <= 17; k++) begin
      cyc(1'b1, 1'b1, (k == 1), sched(k, 8'd255), "rstmid", k);
    end
    cyc(1'b0, 1'b1, 1'b0, sched(0, 8'd0), "rstmid", 18);
    for (int k = 19; k <= 53; k++) begin
      lk = (k >= 23 && k != 29);
      if (k <= 24)      n = 0;
      else if (k <= 30) n = k - 24;
      else              n = k - 31;
      cyc(1'b1, lk, 1'b0, sched(n, 8'd0), "relock", k);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
